// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

    localparam int                         DEFAULT_PAT_W = 4;
    localparam logic [DEFAULT_PAT_W-1:0]   DEFAULT_PAT   = 4'b1010;
    localparam int                         DEFAULT_LEN   = DEFAULT_PAT_W;
    localparam int                         DEFAULT_CNT_W = 8;

    // A requested length of 0 or anything beyond the history depth makes no
    // sense, so it falls back to the full pattern width.
    function automatic int clamp_len(input int len_in, input int pat_w);
        if (len_in < 1 || len_in > pat_w) begin
            return pat_w;
        end
        return len_in;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bit-stream, configuration and status bundle of the sequence detector.
// The master side is the bit source / control logic, the slave is the detector.
interface seq_detector_param_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEFAULT_PAT_W,
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int LEN_W = $clog2(PAT_W + 1)
);

    logic             en;
    logic             b;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic [PAT_W-1:0] mask_in;
    logic [LEN_W-1:0] len_in;
    logic             cnt_clr;
    logic             a;
    logic [CNT_W-1:0] hit_cnt;
    logic             cnt_sat;

    modport master (
        output en, b, overlap, pat_load, pat_in, mask_in, len_in, cnt_clr,
        input  a, hit_cnt, cnt_sat
    );

    modport slave (
        input  en, b, overlap, pat_load, pat_in, mask_in, len_in, cnt_clr,
        output a, hit_cnt, cnt_sat
    );

endinterface

// File: rtl/seq_det_hit_counter.sv
// Saturating match counter; a clear wins over a same-cycle increment.
module seq_det_hit_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             sat;

    assign sat = &count_q;

    // Next count: clear first, then increment unless already pinned at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !sat) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat;

endmodule

// File: rtl/seq_detector_param.sv
// Serial-bit sequence detector with runtime pattern/mask/length, selectable
// overlapping matching, optional registered strobe and a saturating hit count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = DEFAULT_PAT,
    parameter int               CNT_W       = DEFAULT_CNT_W,
    parameter int               REG_OUT     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_detector_param_if.slave  bus
);

    localparam int               LEN_W    = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

    // Configuration registers.
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] mask_q;
    logic [LEN_W-1:0] len_q;

    // Only PAT_W-1 past bits are ever needed: the newest window bit is b itself.
    logic [PAT_W-2:0] hist_q;
    logic [PAT_W-2:0] hist_d;
    logic [LEN_W-1:0] fill_q;
    logic [LEN_W-1:0] fill_d;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] active;
    logic [LEN_W-1:0] len_load;
    logic             fill_ok;
    logic             hit;

    // Window bit i is compared only while it lies inside the active length.
    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_active
            assign active[gi] = (LEN_W'(gi) < len_q);
        end
    endgenerate

    assign len_load = LEN_W'(clamp_len(int'(bus.len_in), PAT_W));

    // Match compare over the current window; a load cycle never matches.
    always_comb begin
        window  = {hist_q, bus.b};
        fill_ok = (fill_q >= (len_q - 1'b1));
        hit     = bus.en && !bus.pat_load && fill_ok &&
                  (((window ^ pat_q) & mask_q & active) == '0);
    end

    // History shift and fill tracking; non-overlapping mode restarts after a hit.
    always_comb begin
        hist_d = window[PAT_W-2:0];
        if (hit && !bus.overlap) begin
            fill_d = '0;
        end else if (fill_q == FILL_MAX) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + 1'b1;
        end
    end

    // Config, history and fill state; a load wipes any partial match.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= PAT_DEFAULT;
            mask_q <= '1;
            len_q  <= LEN_MAX;
            hist_q <= '0;
            fill_q <= '0;
        end else if (bus.pat_load) begin
            pat_q  <= bus.pat_in;
            mask_q <= bus.mask_in;
            len_q  <= len_load;
            hist_q <= '0;
            fill_q <= '0;
        end else if (bus.en) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Detect strobe: straight from the compare, or delayed by one register.
    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic a_q;

            // Registered strobe, cleared by reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= 1'b0;
                end else begin
                    a_q <= hit;
                end
            end

            assign bus.a = a_q;
        end else begin : g_mealy_out
            assign bus.a = hit;
        end
    endgenerate

    seq_det_hit_counter #(
        .CNT_W (CNT_W)
    ) u_hit_counter (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (hit),
        .clr_i   (bus.cnt_clr),
        .count_o (bus.hit_cnt),
        .sat_o   (bus.cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: a Mealy/8-bit-count detector and a registered/3-bit-count
// detector see the same stimulus and are checked against hand-computed hits.
module tb_seq_detector_param;
    import seq_det_pkg::*;

    localparam int K_RST = 0;
    localparam int K_BIT = 1;
    localparam int K_CNT = 2;

    typedef struct {
        int   kind;
        logic ovl;
        logic en;
        logic b;
        logic exp_a;
        int   cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];

    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) if0 ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(3)) if1 ();

    assign if1.en       = if0.en;
    assign if1.b        = if0.b;
    assign if1.overlap  = if0.overlap;
    assign if1.pat_load = if0.pat_load;
    assign if1.pat_in   = if0.pat_in;
    assign if1.mask_in  = if0.mask_in;
    assign if1.len_in   = if0.len_in;
    assign if1.cnt_clr  = if0.cnt_clr;

    seq_detector_param #(.PAT_W(4), .PAT_DEFAULT(4'b1010), .CNT_W(8), .REG_OUT(0)) dut_mealy (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    seq_detector_param #(.PAT_W(4), .PAT_DEFAULT(4'b1010), .CNT_W(3), .REG_OUT(1)) dut_reg (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock of reset; both detectors must come out idle.
    task automatic do_reset(input string name);
        @(negedge clk);
        reset       = 1'b1;
        if0.en       = 1'b0;
        if0.b        = 1'b0;
        if0.overlap  = 1'b0;
        if0.pat_load = 1'b0;
        if0.cnt_clr  = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_a_reg"}, 32'(if1.a), 32'd0);
        chk({name, "_cnt0"}, 32'(if0.hit_cnt), 32'd0);
        chk({name, "_cnt1"}, 32'(if1.hit_cnt), 32'd0);
        chk({name, "_sat1"}, 32'(if1.cnt_sat), 32'd0);
        $display("%s: reset  cnt0=%0d cnt1=%0d a_reg=%0b", name, if0.hit_cnt, if1.hit_cnt, if1.a);
    endtask

    // One bit cycle: Mealy strobe sampled before the edge, registered strobe after.
    task automatic step(input logic e, input logic bv, input logic ov, input logic ld,
                        input logic clr, input logic exp_a, input string name);
        logic a_mealy;
        @(negedge clk);
        reset        = 1'b0;
        if0.en       = e;
        if0.b        = bv;
        if0.overlap  = ov;
        if0.pat_load = ld;
        if0.cnt_clr  = clr;
        #1;
        a_mealy = if0.a;
        chk({name, "_a_mealy"}, 32'(a_mealy), 32'(exp_a));
        @(posedge clk);
        #1;
        chk({name, "_a_reg"}, 32'(if1.a), 32'(exp_a));
        $display("%s: en=%0b b=%0b ov=%0b ld=%0b clr=%0b a_mealy=%0b a_reg=%0b exp=%0b cnt0=%0d",
                 name, e, bv, ov, ld, clr, a_mealy, if1.a, exp_a, if0.hit_cnt);
    endtask

    task automatic check_cnt(input int e, input string name);
        int e1;
        e1 = (e > 7) ? 7 : e;
        chk({name, "_cnt0"}, 32'(if0.hit_cnt), 32'(e));
        chk({name, "_cnt1"}, 32'(if1.hit_cnt), 32'(e1));
        chk({name, "_sat1"}, 32'(if1.cnt_sat), 32'(e >= 7));
        chk({name, "_sat0"}, 32'(if0.cnt_sat), 32'(e >= 255));
        $display("%s: cnt0=%0d cnt1=%0d sat1=%0b exp=%0d", name, if0.hit_cnt, if1.hit_cnt, if1.cnt_sat, e);
    endtask

    task automatic load(input logic [3:0] p, input logic [3:0] m, input logic [2:0] l, input logic ov,
                        input string name);
        if0.pat_in  = p;
        if0.mask_in = m;
        if0.len_in  = l;
        step(1'b1, 1'b1, ov, 1'b1, 1'b0, 1'b0, name);
    endtask

    initial begin
        logic [14:0] s;
        logic [14:0] h1;
        logic [14:0] h2;
        logic [3:0]  bits4;
        logic [3:0]  hits4;

        n_cmp = 0;
        n_bad = 0;
        reset       = 1'b1;
        if0.en       = 1'b0;
        if0.b        = 1'b0;
        if0.overlap  = 1'b0;
        if0.pat_load = 1'b0;
        if0.pat_in   = 4'b0;
        if0.mask_in  = 4'b0;
        if0.len_in   = 3'd0;
        if0.cnt_clr  = 1'b0;

        // Stream in arrival order from the MSB; hit flags aligned the same way.
        s  = 15'b110101011101010;
        h1 = 15'b000010000000100;
        h2 = 15'b000010100000101;

        // Non-overlapping: hits at bits 5 and 13.
        tbl.push_back('{K_RST, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        for (int i = 0; i < 15; i++) tbl.push_back('{K_BIT, 1'b0, 1'b1, s[14-i], h1[14-i], 0});
        tbl.push_back('{K_CNT, 1'b0, 1'b0, 1'b0, 1'b0, 2});
        // Overlapping: hits at bits 5, 7, 13, 15.
        tbl.push_back('{K_RST, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        for (int i = 0; i < 15; i++) tbl.push_back('{K_BIT, 1'b1, 1'b1, s[14-i], h2[14-i], 0});
        tbl.push_back('{K_CNT, 1'b0, 1'b0, 1'b0, 1'b0, 4});
        // Non-overlapping with idle gaps inside both matching windows.
        tbl.push_back('{K_RST, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        for (int i = 0; i < 15; i++) begin
            tbl.push_back('{K_BIT, 1'b0, 1'b1, s[14-i], h1[14-i], 0});
            if (i == 2 || i == 10) begin
                tbl.push_back('{K_BIT, 1'b0, 1'b0, 1'b1, 1'b0, 0});
                tbl.push_back('{K_BIT, 1'b0, 1'b0, 1'b0, 1'b0, 0});
            end
        end
        tbl.push_back('{K_CNT, 1'b0, 1'b0, 1'b0, 1'b0, 2});

        foreach (tbl[k]) begin
            case (tbl[k].kind)
                K_RST:   do_reset($sformatf("vec%0d", k));
                K_BIT:   step(tbl[k].en, tbl[k].b, tbl[k].ovl, 1'b0, 1'b0, tbl[k].exp_a,
                              $sformatf("vec%0d", k));
                default: check_cnt(tbl[k].cnt, $sformatf("vec%0d", k));
            endcase
        end

        // Masked pattern 1?10: 1110 matches on bit 4.
        do_reset("t4_rst");
        load(4'b1010, 4'b1011, 3'd4, 1'b0, "t4_load");
        bits4 = 4'b1110;
        hits4 = 4'b0001;
        for (int i = 0; i < 4; i++) step(1'b1, bits4[3-i], 1'b0, 1'b0, 1'b0, hits4[3-i], $sformatf("t4_mask_b%0d", i + 1));
        check_cnt(1, "t4_mask");

        // len=3 pattern 101, overlapping: hits on bits 3 and 5.
        load(4'b0101, 4'b1111, 3'd3, 1'b1, "t4_load3");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t4_len3_b1");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t4_len3_b2");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t4_len3_b3");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t4_len3_b4");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t4_len3_b5");
        check_cnt(3, "t4_len3");

        // len_in=0 falls back to full length 4.
        load(4'b1010, 4'b1111, 3'd0, 1'b0, "t4_load0");
        bits4 = 4'b1010;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_len0_b1");
        for (int i = 0; i < 4; i++) step(1'b1, bits4[3-i], 1'b0, 1'b0, 1'b0, hits4[3-i], $sformatf("t4_len0_b%0d", i + 2));
        check_cnt(4, "t4_len0");

        // len=1: every bit equal to the pattern bit is a hit.
        load(4'b0001, 4'b1111, 3'd1, 1'b0, "t4_load1");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "t4_len1_b1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_len1_b2");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "t4_len1_b3");
        check_cnt(6, "t4_len1");

        // len_in=5 exceeds the width and also loads as 4.
        load(4'b1010, 4'b1111, 3'd5, 1'b0, "t4_load5");
        for (int i = 0; i < 4; i++) step(1'b1, bits4[3-i], 1'b0, 1'b0, 1'b0, hits4[3-i], $sformatf("t4_len5_b%0d", i + 1));
        check_cnt(7, "t4_len5");

        // Overlapping 1010...: nine hits saturate the 3-bit counter.
        do_reset("t5_rst");
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("t5_p%0d_1", k));
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (k >= 1), $sformatf("t5_p%0d_0", k));
        end
        check_cnt(9, "t5_nine");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t5_more_1");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "t5_more_0");
        check_cnt(10, "t5_ten");
        // Clear coinciding with a hit: strobe still shown, count goes to 0.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t5_clr_1");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "t5_clr_0");
        check_cnt(0, "t5_clr");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t5_post_1");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "t5_post_0");
        check_cnt(1, "t5_post");

        // Reset mid-pattern discards 1,0,1.
        do_reset("t6_rst");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_pre_b1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_pre_b2");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_pre_b3");
        do_reset("t6_mid");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_post_b1");
        for (int i = 0; i < 4; i++) step(1'b1, bits4[3-i], 1'b0, 1'b0, 1'b0, hits4[3-i], $sformatf("t6_post_b%0d", i + 2));
        check_cnt(1, "t6_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
